store_buffer: RTL and testbench

//  In-order store buffer between LSU execute and data memory, downstream of the

---
 rtl/store_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_store_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// In-order store buffer: holds stores from execute until ROB commit, then
// drains committed stores to memory in program order and returns each freed
// entry index to the store allocator.
module store_buffer #(
  parameter int SB_DEPTH   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IW = $clog2(SB_DEPTH),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic [IW-1:0]         alloc_entry,
  input  logic                  exec_valid,
  input  logic [IW-1:0]         exec_entry,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_data,
  input  logic [2:0]            exec_funct3,
  input  logic                  commit_valid,
  input  logic [IW-1:0]         commit_entry,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_conflict,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]         mem_wstrb,
  output logic                  retire_store_valid,
  output logic [IW-1:0]         retire_entry,
  output logic                  committed_pending
);

  localparam int OFFW = $clog2(SW);
  localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RET  = 2'd2
  } drain_state_t;

  // Byte-lane strobes for a store of the given size at the given byte offset.
  function automatic logic [SW-1:0] strb_of(input logic [2:0] f3, input logic [OFFW-1:0] off);
    logic [SW-1:0] s;
    case (f3)
      3'b000:  s = {{(SW-1){1'b0}}, 1'b1} << off;
      3'b001:  s = {{(SW-2){1'b0}}, 2'b11} << off;
      3'b010:  s = {SW{1'b1}};
      default: s = {SW{1'b0}};
    endcase
    return s;
  endfunction

  // Move store data onto the byte lanes selected by the address offset.
  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [DATA_WIDTH-1:0] d, input logic [OFFW-1:0] off);
    return d << {off, 3'b000};
  endfunction

  logic [SB_DEPTH-1:0]   busy_r, executed_r, committed_r;
  logic [ADDR_WIDTH-1:0] entry_addr_r  [SB_DEPTH];
  logic [DATA_WIDTH-1:0] entry_wdata_r [SB_DEPTH];
  logic [SW-1:0]         entry_wstrb_r [SB_DEPTH];
  logic [IW-1:0]         ring_r        [SB_DEPTH];
  logic [IW:0]           head_r, tail_r;

  drain_state_t          state_r, state_nxt_s;
  logic [IW-1:0]         head_idx_s;
  logic                  ring_empty_s, head_ready_s, load_req_s, handshake_s;
  logic                  ld_conflict_s;

  logic                  mem_req_valid_r, retire_store_valid_r, committed_pending_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [SW-1:0]         mem_wstrb_r;
  logic [IW-1:0]         retire_entry_r;

  // Drain FSM next state: launch the oldest store once it is executed and committed.
  always_comb begin
    head_idx_s   = ring_r[head_r[IW-1:0]];
    ring_empty_s = (head_r == tail_r);
    head_ready_s = 1'b0;
    state_nxt_s  = state_r;
    load_req_s   = 1'b0;
    handshake_s  = 1'b0;
    if (!ring_empty_s) begin
      head_ready_s = busy_r[head_idx_s] & executed_r[head_idx_s] & committed_r[head_idx_s];
    end else begin
      head_ready_s = 1'b0;
    end
    case (state_r)
      S_IDLE: begin
        if (head_ready_s) begin
          state_nxt_s = S_REQ;
          load_req_s  = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_valid_r && mem_req_ready) begin
          state_nxt_s = S_RET;
          handshake_s = 1'b1;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_RET:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Load hazard: any live store that is unresolved or targets the same word.
  always_comb begin
    ld_conflict_s = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ld_valid && busy_r[i] &&
          (!executed_r[i] || (((entry_addr_r[i] ^ ld_addr) >> OFFW) == {ADDR_WIDTH{1'b0}}))) begin
        ld_conflict_s = 1'b1;
      end else begin
        ld_conflict_s = ld_conflict_s;
      end
    end
  end

  // Drain FSM state register; flush returns it to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else if (flush) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entry flags and ring pointers; a drained entry is freed at its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= {SB_DEPTH{1'b0}};
      executed_r  <= {SB_DEPTH{1'b0}};
      committed_r <= {SB_DEPTH{1'b0}};
      head_r      <= {(IW+1){1'b0}};
      tail_r      <= {(IW+1){1'b0}};
    end else if (flush) begin
      busy_r      <= {SB_DEPTH{1'b0}};
      executed_r  <= {SB_DEPTH{1'b0}};
      committed_r <= {SB_DEPTH{1'b0}};
      head_r      <= {(IW+1){1'b0}};
      tail_r      <= {(IW+1){1'b0}};
    end else begin
      if (handshake_s) begin
        busy_r[head_idx_s]      <= 1'b0;
        executed_r[head_idx_s]  <= 1'b0;
        committed_r[head_idx_s] <= 1'b0;
        head_r                  <= head_r + PTR_ONE;
      end
      if (alloc_valid) begin
        busy_r[alloc_entry]      <= 1'b1;
        executed_r[alloc_entry]  <= 1'b0;
        committed_r[alloc_entry] <= 1'b0;
        tail_r                   <= tail_r + PTR_ONE;
      end
      if (exec_valid) begin
        executed_r[exec_entry] <= 1'b1;
      end
      if (commit_valid) begin
        committed_r[commit_entry] <= 1'b1;
      end
    end
  end

  // Payload storage; validity is tracked by the flags and ring pointers above.
  always_ff @(posedge clk) begin
    if (alloc_valid && !flush) begin
      ring_r[tail_r[IW-1:0]] <= alloc_entry;
    end
    if (exec_valid && !flush) begin
      entry_addr_r[exec_entry]  <= exec_addr;
      entry_wdata_r[exec_entry] <= lane_data(exec_data, exec_addr[OFFW-1:0]);
      entry_wstrb_r[exec_entry] <= strb_of(exec_funct3, exec_addr[OFFW-1:0]);
    end
  end

  // Memory request, retire pulse and pending-commit status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid_r      <= 1'b0;
      mem_addr_r           <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r          <= {DATA_WIDTH{1'b0}};
      mem_wstrb_r          <= {SW{1'b0}};
      retire_store_valid_r <= 1'b0;
      retire_entry_r       <= {IW{1'b0}};
      committed_pending_r  <= 1'b0;
    end else if (flush) begin
      mem_req_valid_r      <= 1'b0;
      retire_store_valid_r <= 1'b0;
      retire_entry_r       <= {IW{1'b0}};
      committed_pending_r  <= 1'b0;
    end else begin
      if (load_req_s) begin
        mem_req_valid_r <= 1'b1;
        mem_addr_r      <= {entry_addr_r[head_idx_s][ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        mem_wdata_r     <= entry_wdata_r[head_idx_s];
        mem_wstrb_r     <= entry_wstrb_r[head_idx_s];
      end else if (handshake_s) begin
        mem_req_valid_r <= 1'b0;
      end
      retire_store_valid_r <= handshake_s;
      if (handshake_s) begin
        retire_entry_r <= head_idx_s;
      end
      committed_pending_r <= |(busy_r & committed_r);
    end
  end

  assign ld_conflict        = ld_conflict_s;
  assign mem_req_valid      = mem_req_valid_r;
  assign mem_addr           = mem_addr_r;
  assign mem_wdata          = mem_wdata_r;
  assign mem_wstrb          = mem_wstrb_r;
  assign retire_store_valid = retire_store_valid_r;
  assign retire_entry       = retire_entry_r;
  assign committed_pending  = committed_pending_r;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes and retires are
// queued at commit and matched by a monitor as the buffer drains.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alloc_valid, exec_valid, commit_valid, ld_valid, mem_req_ready;
  logic [3:0]  alloc_entry, exec_entry, commit_entry, retire_entry;
  logic [31:0] exec_addr, exec_data, ld_addr, mem_addr, mem_wdata;
  logic [2:0]  exec_funct3;
  logic [3:0]  mem_wstrb;
  logic        ld_conflict, mem_req_valid, retire_store_valid, committed_pending;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  entry;
  } exp_t;

  exp_t        model [16];
  exp_t        wr_q [$];
  logic [3:0]  ret_q [$];
  exp_t        mon_e;
  logic        ret_prev = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  store_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_entry(alloc_entry),
    .exec_valid(exec_valid), .exec_entry(exec_entry), .exec_addr(exec_addr),
    .exec_data(exec_data), .exec_funct3(exec_funct3),
    .commit_valid(commit_valid), .commit_entry(commit_entry),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .retire_store_valid(retire_store_valid), .retire_entry(retire_entry),
    .committed_pending(committed_pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [3:0] e, input logic [31:0] a,
                                    input logic [31:0] d, input logic [2:0] f3);
    exp_t r;
    r.entry = e;
    r.addr  = {a[31:2], 2'b00};
    case (f3)
      3'b000:  r.strb = 4'b0001 << a[1:0];
      3'b001:  r.strb = 4'b0011 << a[1:0];
      default: r.strb = 4'b1111;
    endcase
    r.data = d << (32'(a[1:0]) * 8);
    return r;
  endfunction

  // Monitor: compare every handshake and retire against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (wr_q.size() == 0) begin
          check_eq("unexpected_write", 64'd1, 64'd0);
        end else begin
          mon_e = wr_q.pop_front();
          check_eq("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
          check_eq("mem_wdata", 64'(mem_wdata), 64'(mon_e.data));
          check_eq("mem_wstrb", 64'(mem_wstrb), 64'(mon_e.strb));
        end
      end
      if (retire_store_valid) begin
        check_eq("retire_single_pulse", 64'(ret_prev), 64'd0);
        if (ret_q.size() == 0) begin
          check_eq("unexpected_retire", 64'd1, 64'd0);
        end else begin
          check_eq("retire_entry", 64'(retire_entry), 64'(ret_q.pop_front()));
        end
      end
      ret_prev = retire_store_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [3:0] e);
    alloc_valid = 1'b1; alloc_entry = e;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic drive_exec(input logic [3:0] e, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f3);
    model[e]   = make_exp(e, a, d, f3);
    exec_valid = 1'b1; exec_entry = e; exec_addr = a; exec_data = d; exec_funct3 = f3;
  endtask

  task automatic do_exec(input logic [3:0] e, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
    drive_exec(e, a, d, f3);
    tick();
    exec_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] e);
    wr_q.push_back(model[e]);
    ret_q.push_back(e);
    commit_valid = 1'b1; commit_entry = e;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input logic exp);
    ld_valid = 1'b1; ld_addr = a;
    #1;
    check_eq(tag, 64'(ld_conflict), 64'(exp));
    ld_valid = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while ((wr_q.size() != 0 || ret_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_done", 64'(wr_q.size() + ret_q.size()), 64'd0);
    tick();
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!mem_req_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("req_seen", 64'(mem_req_valid), 64'd1);
  endtask

  logic [31:0] cap_addr, cap_data, a6;
  logic [3:0]  cap_strb;
  logic [2:0]  f6;

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; exec_valid = 1'b0; commit_valid = 1'b0;
    ld_valid = 1'b0; mem_req_ready = 1'b1; alloc_entry = 4'd0; exec_entry = 4'd0;
    commit_entry = 4'd0; exec_addr = 32'd0; exec_data = 32'd0; exec_funct3 = 3'd0; ld_addr = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rst_retire_valid", 64'(retire_store_valid), 64'd0);
    check_eq("rst_retire_entry", 64'(retire_entry), 64'd0);
    check_eq("rst_committed_pending", 64'(committed_pending), 64'd0);
    probe("rst_ld_conflict", 32'h0000_0010, 1'b0);

    // Reset while a request is stalled in REQ.
    mem_req_ready = 1'b0;
    do_alloc(4'd2);
    do_exec(4'd2, 32'h0000_0010, 32'h1234_5678, 3'b010);
    do_commit(4'd2);
    wait_req(10);
    rst = 1'b1;
    wr_q.delete();
    ret_q.delete();
    tick();
    check_eq("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_eq("midrst_retire_valid", 64'(retire_store_valid), 64'd0);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    probe("midrst_entry_cleared", 32'h0000_0010, 1'b0);

    // Halfword store at byte offset 2; launch one cycle after commit lands.
    do_alloc(4'd3);
    do_exec(4'd3, 32'h0000_1002, 32'h0000_ABCD, 3'b001);
    wr_q.push_back('{addr: 32'h0000_1000, data: 32'hABCD_0000, strb: 4'b1100, entry: 4'd3});
    ret_q.push_back(4'd3);
    commit_valid = 1'b1; commit_entry = 4'd3;
    tick();
    commit_valid = 1'b0;
    check_eq("sh_req_not_yet", 64'(mem_req_valid), 64'd0);
    tick();
    check_eq("sh_req_latency", 64'(mem_req_valid), 64'd1);
    wait_drained(20);
    check_eq("sh_pending_dropped", 64'(committed_pending), 64'd0);

    // Out-of-order execute, in-order drain.
    do_alloc(4'd0);
    do_alloc(4'd1);
    do_exec(4'd1, 32'h0000_0040, 32'h1111_1111, 3'b010);
    do_exec(4'd0, 32'h0000_0045, 32'h0000_0022, 3'b000);
    do_commit(4'd0);
    do_commit(4'd1);
    wait_drained(30);

    // Back-pressure: request held stable, no retire until handshake.
    mem_req_ready = 1'b0;
    do_alloc(4'd7);
    do_exec(4'd7, 32'h0000_0083, 32'h0000_00A5, 3'b000);
    do_commit(4'd7);
    wait_req(10);
    cap_addr = mem_addr; cap_data = mem_wdata; cap_strb = mem_wstrb;
    check_eq("bp_wstrb", 64'(cap_strb), 64'h8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid_held", 64'(mem_req_valid), 64'd1);
      check_eq("bp_addr_stable", 64'(mem_addr), 64'(cap_addr));
      check_eq("bp_data_stable", 64'(mem_wdata), 64'(cap_data));
      check_eq("bp_no_retire", 64'(retire_store_valid), 64'd0);
    end
    check_eq("bp_pending", 64'(committed_pending), 64'd1);
    mem_req_ready = 1'b1;
    wait_drained(20);

    // Load conflict: unexecuted entries and same-word matches.
    do_alloc(4'd5);
    do_exec(4'd5, 32'h0000_0200, 32'hDEAD_BEEF, 3'b010);
    do_alloc(4'd6);
    probe("ld_same_word", 32'h0000_0202, 1'b1);
    probe("ld_unexecuted_any", 32'h0000_0400, 1'b1);
    do_exec(4'd6, 32'h0000_0300, 32'hCAFE_F00D, 3'b010);
    probe("ld_no_match", 32'h0000_0400, 1'b0);
    probe("ld_match_e6", 32'h0000_0302, 1'b1);
    do_commit(4'd5);
    wait_drained(20);
    probe("ld_after_drain", 32'h0000_0202, 1'b0);
    probe("ld_e6_still", 32'h0000_0303, 1'b1);
    do_commit(4'd6);
    wait_drained(20);
    probe("ld_all_drained", 32'h0000_0300, 1'b0);

    // Fill all 16 entries (15..0), exec overlapping alloc, commit, drain with wrap.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        alloc_valid = 1'b1; alloc_entry = 4'(15 - i);
      end else begin
        alloc_valid = 1'b0;
      end
      if (i > 0) begin
        f6 = 3'((i - 1) % 3);
        a6 = 32'h0000_2000 + 32'((i - 1) * 16) +
             ((f6 == 3'b000) ? 32'((i - 1) % 4) : (f6 == 3'b001) ? 32'(((i - 1) % 2) * 2) : 32'd0);
        drive_exec(4'(16 - i), a6, $urandom, f6);
      end else begin
        exec_valid = 1'b0;
      end
      tick();
    end
    exec_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_commit(4'(15 - i));
    end
    wait_drained(200);

    // Flush with uncommitted entries; a same-cycle alloc is dropped.
    do_alloc(4'd1);
    do_alloc(4'd2);
    do_alloc(4'd3);
    do_exec(4'd1, 32'h0000_3000, 32'h5555_AAAA, 3'b010);
    probe("pre_flush_conflict", 32'h0000_3000, 1'b1);
    check_eq("flush_cp_zero", 64'(committed_pending), 64'd0);
    flush = 1'b1; alloc_valid = 1'b1; alloc_entry = 4'd4;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    probe("flush_cleared", 32'h0000_3000, 1'b0);
    probe("flush_alloc_dropped", 32'h0000_1234, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("flush_no_req", 64'(mem_req_valid), 64'd0);
      tick();
    end
    do_alloc(4'd9);
    do_exec(4'd9, 32'h0000_5006, 32'h0000_007E, 3'b000);
    do_commit(4'd9);
    wait_drained(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
